// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared constants, types and helpers for the binary32 multiplier
package fp32_pkg;

   localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
   localparam logic [31:0] FP32_PINF = 32'h7F800000;
   localparam logic [31:0] FP32_MAXF = 32'h7F7FFFFF;
   localparam int          BIAS      = 127;
   localparam int          EW        = 12;

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RDN = 2'b10,
      RM_RUP = 2'b11
   } rm_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] mant;
      logic        is_zero;
      logic        is_inf;
      logic        is_nan;
   } fp32_unp_t;

   // Subnormals get effective exponent 1 and a clear hidden bit.
   function automatic fp32_unp_t unpack(input logic [31:0] x);
      fp32_unp_t u;
      u.sign    = x[31];
      u.exp     = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      u.mant    = {(x[30:23] != 8'd0), x[22:0]};
      u.is_zero = (x[30:23] == 8'd0) && (x[22:0] == 23'd0);
      u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      return u;
   endfunction

   function automatic logic [5:0] lzc48(input logic [47:0] x);
      logic [5:0] n;
      n = 6'd48;
      for (int i = 0; i < 48; i++) begin
         if (x[i]) n = 6'(47 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// rtl/fp32_round_pack.sv - denormalize, round and pack a normalized product into binary32
module fp32_round_pack
   import fp32_pkg::*;
(
   input  logic                 sign,
   input  logic signed [EW-1:0] exp,
   input  logic [26:0]          sig,
   input  rm_t                  rm,
   output logic [31:0]          res
);

   logic [EW-1:0] k;
   logic [26:0]   sh;
   logic          sticky;
   logic [7:0]    ef;
   logic          g;
   logic          rest;
   logic          inc;
   logic [31:0]   mag;
   logic          ovf;
   logic          big;

   // sig[26] is the hidden bit, sig[25:3] the fraction, sig[2:0] guard/round/sticky.
   always_comb begin
      k      = '0;
      sh     = sig;
      sticky = 1'b0;
      ef     = exp[7:0];
      if (exp <= 0) begin
         k  = EW'(1) - exp;
         ef = 8'd0;
         if (k >= EW'(27)) begin
            sh     = '0;
            sticky = |sig;
         end else begin
            sh     = sig >> k;
            sticky = |(sig & ((27'd1 << k) - 27'd1));
         end
      end

      g    = sh[2];
      rest = sh[1] | sh[0] | sticky;
      case (rm)
         RM_RNE:  inc = g & (rest | sh[3]);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (g | rest);
         RM_RUP:  inc = ~sign & (g | rest);
         default: inc = 1'b0;
      endcase

      // A fraction carry ripples into the exponent field, which also lifts a
      // subnormal to the minimum normal.
      mag = {1'b0, ef, sh[25:3]} + 32'(inc);
      ovf = (exp >= 255) || (mag[30:23] == 8'hFF);
      big = (rm == RM_RNE) || (rm == RM_RDN && sign) || (rm == RM_RUP && !sign);

      if (ovf) res = big ? {sign, FP32_PINF[30:0]} : {sign, FP32_MAXF[30:0]};
      else     res = {sign, mag[30:0]};
   end

endmodule

// File: rtl/fp32_mul.sv
// rtl/fp32_mul.sv - three-cycle pipelined binary32 multiplier with selectable rounding
module fp32_mul
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  rm,
   output logic [31:0] s,
   output logic        valid
);

   fp32_unp_t            ua, ub;
   logic                 sg0, nan0, inf0, zero0, sp0;
   logic [31:0]          spv0;
   logic signed [EW-1:0] esum0;

   logic                 v1, sg1, sp1;
   logic signed [EW-1:0] e1;
   logic [23:0]          ma1, mb1;
   logic [31:0]          spv1;
   rm_t                  rm1;

   logic                 v2, sg2, sp2;
   logic signed [EW-1:0] e2;
   logic [47:0]          p2;
   logic [31:0]          spv2;
   rm_t                  rm2;

   logic [5:0]           lz;
   logic [47:0]          pn;
   logic signed [EW-1:0] en;

   logic                 v3, sg3, sp3;
   logic signed [EW-1:0] e3;
   logic [26:0]          n3;
   logic [31:0]          spv3;
   rm_t                  rm3;
   logic [31:0]          packed_res;

   always_comb begin
      ua    = unpack(a);
      ub    = unpack(b);
      sg0   = ua.sign ^ ub.sign;
      nan0  = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_zero) | (ua.is_zero & ub.is_inf);
      inf0  = ua.is_inf | ub.is_inf;
      zero0 = ua.is_zero | ub.is_zero;
      sp0   = nan0 | inf0 | zero0;
      if (nan0)      spv0 = FP32_QNAN;
      else if (inf0) spv0 = {sg0, FP32_PINF[30:0]};
      else           spv0 = {sg0, 31'd0};
      esum0 = EW'(ua.exp) + EW'(ub.exp) - EW'(BIAS);
   end

   // Product 1.x * 2^E sits at bit 46; a leading one at bit 47 means exponent E+1.
   always_comb begin
      lz = lzc48(p2);
      pn = p2 << lz;
      en = e2 + EW'(1) - EW'(lz);
   end

   fp32_round_pack u_round_pack (
      .sign (sg3),
      .exp  (e3),
      .sig  (n3),
      .rm   (rm3),
      .res  (packed_res)
   );

   always_ff @(posedge clk) begin
      sg1  <= sg0;
      sp1  <= sp0;
      spv1 <= spv0;
      e1   <= esum0;
      ma1  <= ua.mant;
      mb1  <= ub.mant;
      rm1  <= rm_t'(rm);

      sg2  <= sg1;
      sp2  <= sp1;
      spv2 <= spv1;
      e2   <= e1;
      p2   <= 48'(ma1) * 48'(mb1);
      rm2  <= rm1;

      sg3  <= sg2;
      sp3  <= sp2;
      spv3 <= spv2;
      e3   <= en;
      n3   <= {pn[47:22], |pn[21:0]};
      rm3  <= rm2;

      if (rst) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         v3    <= 1'b0;
         valid <= 1'b0;
         s     <= 32'd0;
      end else begin
         v1    <= ena;
         v2    <= v1;
         v3    <= v2;
         valid <= v3;
         if (v3) s <= sp3 ? spv3 : packed_res;
      end
   end

endmodule

// File: tb/tb_fp32_mul.sv
// tb/tb_fp32_mul.sv - directed-vector bench for fp32_mul
module tb_fp32_mul;

   logic        clk;
   logic        rst;
   logic        ena;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  rm;
   logic [31:0] s;
   logic        valid;

   int n_tests;
   int n_fail;

   int          got_n;
   int          first_c;
   int          last_c;
   logic [31:0] got [3];

   fp32_mul dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .a     (a),
      .b     (b),
      .rm    (rm),
      .s     (s),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [1:0] op_rm, input logic [31:0] exp);
      int lat;
      @(negedge clk);
      a   = op_a;
      b   = op_b;
      rm  = op_rm;
      ena = 1'b1;
      @(negedge clk);
      ena = 1'b0;
      lat = 0;
      while (!valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk(tag, s, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      ena = 1'b0;
      a   = '0;
      b   = '0;
      rm  = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_s", s, 32'h0);
      chk("rst_valid", 32'(valid), 32'd0);

      run_op("mul_2x3", 32'h40000000, 32'h40400000, 2'b00, 32'h40C00000);
      @(negedge clk);
      chk("pulse_width", 32'(valid), 32'd0);
      chk("hold_s", s, 32'h40C00000);

      run_op("mul_1p5xm2p5", 32'h3FC00000, 32'hC0200000, 2'b00, 32'hC0700000);
      run_op("mul_2p5x3p5",  32'h40200000, 32'h40600000, 2'b00, 32'h410C0000);
      run_op("inf_x_zero",   32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000);
      run_op("nan_x_5",      32'h7FC12345, 32'h40A00000, 2'b00, 32'h7FC00000);
      run_op("ovf_rne",      32'h7F000000, 32'h40000000, 2'b00, 32'h7F800000);
      run_op("ovf_rtz",      32'h7F000000, 32'h40000000, 2'b01, 32'h7F7FFFFF);
      run_op("ovf_rdn",      32'h7F000000, 32'h40000000, 2'b10, 32'h7F7FFFFF);
      run_op("ovf_rup",      32'h7F000000, 32'h40000000, 2'b11, 32'h7F800000);
      run_op("ulp_sq_rne",   32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002);
      run_op("ulp_sq_rup",   32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800003);
      run_op("subnorm",      32'h00800000, 32'h3F000000, 2'b00, 32'h00400000);
      run_op("tiny_rne",     32'h00000001, 32'h3F000000, 2'b00, 32'h00000000);
      run_op("tiny_rup",     32'h00000001, 32'h3F000000, 2'b11, 32'h00000001);
      run_op("neg_inf",      32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000);
      run_op("neg_zero",     32'h80000000, 32'h40000000, 2'b00, 32'h80000000);

      // three launches on consecutive cycles
      @(negedge clk);
      a = 32'h40000000; b = 32'h40400000; rm = 2'b00; ena = 1'b1;
      @(negedge clk);
      a = 32'h3FC00000; b = 32'hC0200000;
      @(negedge clk);
      a = 32'h40200000; b = 32'h40600000;
      @(negedge clk);
      ena = 1'b0;
      got_n   = 0;
      first_c = -1;
      last_c  = -1;
      for (int c = 0; c < 8; c++) begin
         if (valid) begin
            if (got_n < 3) got[got_n] = s;
            if (first_c < 0) first_c = c;
            last_c = c;
            got_n++;
         end
         @(negedge clk);
      end
      chk("pipe_count", 32'(got_n), 32'd3);
      chk("pipe_span", 32'(last_c - first_c), 32'd2);
      chk("pipe_r0", got[0], 32'h40C00000);
      chk("pipe_r1", got[1], 32'hC0700000);
      chk("pipe_r2", got[2], 32'h410C0000);

      // reset while an operation is in flight
      @(negedge clk);
      a = 32'h40000000; b = 32'h40400000; rm = 2'b00; ena = 1'b1;
      @(negedge clk);
      ena = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_s", s, 32'h0);
      chk("midrst_valid", 32'(valid), 32'd0);
      got_n = 0;
      for (int c = 0; c < 6; c++) begin
         if (valid) got_n++;
         @(negedge clk);
      end
      chk("midrst_stale", 32'(got_n), 32'd0);
      chk("midrst_hold", s, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp32_mul.md
Name: fp32_mul

Overview:
- Pipelined IEEE-754 binary32 multiplier with selectable rounding mode; computes s = a × b.
- Sits in the arithmetic datapath as a fixed-latency leaf unit.
- Single-cycle `ena` pulse launches an operation; `valid` pulses when the result is ready.
- Fully pipelined: can accept a new operation every cycle.

Parameters:
- None. Format is fixed at binary32 and latency is fixed at 3 cycles.

Ports:
- clk    in   1   rising-edge clock
- rst    in   1   synchronous, active-high reset
- ena    in   1   operation launch; a, b, rm sampled on the clk edge where ena=1
- a      in   32  operand A (binary32)
- b      in   32  operand B (binary32)
- rm     in   2   rounding mode: 00 nearest-even, 01 toward zero, 10 toward −inf, 11 toward +inf
- s      out  32  product (binary32), registered
- valid  out  1   one-cycle pulse, s is valid in that cycle

Behaviour:
- Reset (sampled on clk edge with rst=1):
  - s = 0x00000000, valid = 0, all internal stage-valid bits = 0.
  - In-flight operations are discarded; no valid pulse follows reset.
- Latency:
  - ena sampled high at edge N → valid=1 and s=result after edge N+3.
  - valid stays high for exactly one cycle per accepted operation.
  - Back-to-back ena gives back-to-back valid pulses.
- s holds its last result while valid=0.
- Stage 1, unpack/classify:
  - Sign = sa ^ sb.
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Effective exponent is 1 for subnormals; hidden bit is 0 for subnormals, 1 for normals.
  - Exponent sum = ea + eb − 127, kept signed with ≥10 bits.
  - Special-case flag and special result are latched.
- Stage 2, multiply: 24×24 → 48-bit unsigned significand product.
- Stage 3, normalize, round and pack:
  - Leading-zero count normalizes the product, adjusting the exponent.
  - If the exponent ≤ 0, right-shift into subnormal range, collecting sticky bits.
  - Round using guard, round and sticky bits per rm.
  - Round-up carry-out increments the exponent; a subnormal may round up to the minimum normal.
- Special results, which override the arithmetic path:
  - Any NaN operand → 0x7FC00000, a canonical quiet NaN. The input payload is not propagated.
  - Inf × 0 or 0 × Inf → 0x7FC00000.
  - Inf × finite-nonzero or Inf × Inf → sign-correct infinity.
  - 0 × finite → sign-correct zero.
- Overflow (exponent ≥ 255 after rounding):
  - rm=00 → ±inf.
  - rm=01 → ±0x7F7FFFFF (max finite).
  - rm=10 → −inf if negative, +max finite if positive.
  - rm=11 → +inf if positive, −max finite if negative.
- Underflow:
  - Gradual: subnormal results are produced.
  - Total underflow rounds to ±0 or ±min-subnormal per rm.
- Zero results always carry sign sa ^ sb.
- No exception flags are output.
- Inputs a, b, rm are don't-care when ena=0.

Decomposition:
- Shared package fp32_pkg holds:
  - Constants: FP32_QNAN = 32'h7FC00000, FP32_PINF = 32'h7F800000, FP32_MAXF = 32'h7F7FFFFF, BIAS = 127.
  - Rounding-mode encodings: RM_RNE, RM_RTZ, RM_RDN, RM_RUP.
  - A struct type for unpacked operands: sign, exp, mant, is_zero, is_inf, is_nan.
- One natural sub-module, fp32_round_pack:
  - Inputs: sign, signed exponent, normalized significand with G/R/S, rm.
  - Output: packed binary32.
  - Includes overflow and underflow handling.
- The leading-zero count can be a function in fp32_pkg.

Test Plan:
- 0x40000000 × 0x40400000 (2.0×3.0), rm=00 → s=0x40C00000, valid exactly 3 cycles after ena.
- 0x3FC00000 × 0xC0200000 (1.5×−2.5) → 0xC0700000; then 0x40200000 × 0x40600000 (2.5×3.5) → 0x410C0000.
- 0x7F800000 × 0x00000000 (Inf×0) → 0x7FC00000; 0x7FC12345 × 0x40A00000 (NaN×5.0) → 0x7FC00000.
- Overflow 0x7F000000 × 0x40000000 for each rm 00/01/10/11 → 0x7F800000 / 0x7F7FFFFF / 0x7F7FFFFF / 0x7F800000.
- Rounding and underflow:
  - 0x3F800001 × 0x3F800001: rm=00 → 0x3F800002, rm=11 → 0x3F800003.
  - 0x00800000 × 0x3F000000 → 0x00400000 (subnormal).
  - 0x00000001 × 0x3F000000: rm=00 → 0x00000000, rm=11 → 0x00000001.
- Pipelining and reset:
  - ena high 3 consecutive cycles with distinct operands → 3 consecutive valid pulses with results in order.
  - rst asserted mid-flight → s=0, valid stays 0, no stale pulse afterward.
